// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM state
// encoding, default ack timeout, and the legality check for memory ops.
package mem_access_stage_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int MAX_WAIT_DEFAULT = 255;

    // funct3 access size / sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    // True when a memory op may be issued: known size code and natural
    // alignment. Unsigned sizes only make sense for loads.
    function automatic logic mem_op_ok(input logic [2:0] f3,
                                       input logic       is_store,
                                       input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !off[0];
            F3_HU:   ok = !is_store && !off[0];
            F3_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load data extraction: picks the addressed byte/half out of the read word
// and sign- or zero-extends it; words pass through.
//  rdata  : 32-bit word returned by data memory
//  off    : byte offset addr[1:0]
//  funct3 : access size/sign code
//  result : 32-bit value written back to the register file
module mem_access_stage_load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'b0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX results into data-memory req/ack transactions
// (store strobes, load extension), stalls upstream while an access is
// outstanding, and registers the MEM/WB payload.
//  clk, rst_n            : clock, asynchronous active-low reset
//  valid_in, flush       : incoming op qualifier / squash of incoming op
//  stall_out             : high while an access is in flight
//  alu_result_in ..      : EX outputs (address/result, store data, control)
//  dmem_*                : req/ack data-memory port
//  valid_out .. fault_out: registered MEM/WB payload
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            flush,
    output logic            stall_out,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            MemREAD_in,
    input  logic [1:0]      MemWrite_in,
    input  logic            MemtoReg_in,
    input  logic            RegWrite_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            valid_out,
    output logic [4:0]      rd_out,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] load_data_out,
    output logic            fault_out
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_e          state_reg, state_next;
    logic [7:0]      wait_reg, wait_next;

    // Op latched at the accept edge and replayed on the memory port
    logic [XLEN-1:0] addr_reg, wdata_reg;
    logic [3:0]      wstrb_reg;
    logic            we_reg, regwrite_reg, memtoreg_reg;
    logic [4:0]      rd_reg;
    logic [2:0]      funct3_reg;

    // MEM/WB payload
    logic            valid_out_reg, regwrite_out_reg, memtoreg_out_reg, fault_out_reg;
    logic [4:0]      rd_out_reg;
    logic [XLEN-1:0] alu_out_reg, load_out_reg;

    logic            accept, is_store, is_mem, op_ok, in_access;
    logic [3:0]      wstrb_next;
    logic [XLEN-1:0] wdata_next, ext_data;
    logic            latch_en, pay_en, pay_regwrite, pay_memtoreg, pay_fault;
    logic [4:0]      pay_rd;
    logic [XLEN-1:0] pay_alu, pay_load;

    mem_access_stage_load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .off    (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (ext_data)
    );

    assign in_access = (state_reg == ST_ACCESS);
    assign accept    = (state_reg == ST_IDLE) && valid_in && !flush;
    assign is_store  = (MemWrite_in != 2'b00);
    assign is_mem    = MemREAD_in || is_store;
    assign op_ok     = mem_op_ok(funct3_in, is_store, alu_result_in[1:0]);

    // Store lane replication and byte enables; loads carry no strobes
    always_comb begin
        wstrb_next = 4'b0000;
        wdata_next = store_data_in;
        if (is_store) begin
            case (funct3_in[1:0])
                2'b00: begin
                    wstrb_next = 4'b0001 << alu_result_in[1:0];
                    wdata_next = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    wstrb_next = 4'b0011 << alu_result_in[1:0];
                    wdata_next = {2{store_data_in[15:0]}};
                end
                default: wstrb_next = 4'b1111;
            endcase
        end
    end

    // Next state and payload selection
    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        latch_en     = 1'b0;
        pay_en       = 1'b0;
        pay_rd       = rd_in;
        pay_regwrite = RegWrite_in;
        pay_memtoreg = MemtoReg_in;
        pay_alu      = alu_result_in;
        pay_load     = '0;
        pay_fault    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        pay_en = 1'b1;
                    end else if (!op_ok) begin
                        pay_en       = 1'b1;
                        pay_fault    = 1'b1;
                        pay_regwrite = 1'b0;
                    end else begin
                        latch_en   = 1'b1;
                        wait_next  = 8'd0;
                        state_next = ST_ACCESS;
                    end
                end
            end
            default: begin
                pay_rd       = rd_reg;
                pay_regwrite = regwrite_reg;
                pay_memtoreg = memtoreg_reg;
                pay_alu      = addr_reg;
                if (dmem_ack) begin
                    pay_en     = 1'b1;
                    pay_load   = we_reg ? '0 : ext_data;
                    state_next = ST_IDLE;
                end else if (wait_reg >= WAIT_LIMIT) begin
                    // This cycle is the MAX_WAIT-th without an ack
                    pay_en       = 1'b1;
                    pay_fault    = 1'b1;
                    pay_regwrite = 1'b0;
                    state_next   = ST_IDLE;
                end else if (wait_reg != 8'hFF) begin
                    wait_next = wait_reg + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            wait_reg         <= '0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            wstrb_reg        <= '0;
            we_reg           <= 1'b0;
            rd_reg           <= '0;
            regwrite_reg     <= 1'b0;
            memtoreg_reg     <= 1'b0;
            funct3_reg       <= '0;
            valid_out_reg    <= 1'b0;
            rd_out_reg       <= '0;
            regwrite_out_reg <= 1'b0;
            memtoreg_out_reg <= 1'b0;
            alu_out_reg      <= '0;
            load_out_reg     <= '0;
            fault_out_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            valid_out_reg <= pay_en;
            if (latch_en) begin
                addr_reg     <= alu_result_in;
                wdata_reg    <= wdata_next;
                wstrb_reg    <= wstrb_next;
                we_reg       <= is_store;
                rd_reg       <= rd_in;
                regwrite_reg <= RegWrite_in;
                memtoreg_reg <= MemtoReg_in;
                funct3_reg   <= funct3_in;
            end
            if (pay_en) begin
                rd_out_reg       <= pay_rd;
                regwrite_out_reg <= pay_regwrite;
                memtoreg_out_reg <= pay_memtoreg;
                alu_out_reg      <= pay_alu;
                load_out_reg     <= pay_load;
                fault_out_reg    <= pay_fault;
            end
        end
    end

    // Memory port is driven straight from state so reset drops req at once
    assign stall_out      = in_access;
    assign dmem_req       = in_access;
    assign dmem_we        = in_access && we_reg;
    assign dmem_addr      = in_access ? {addr_reg[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata     = in_access ? wdata_reg : '0;
    assign dmem_wstrb     = in_access ? wstrb_reg : 4'b0000;

    assign valid_out      = valid_out_reg;
    assign rd_out         = rd_out_reg;
    assign RegWrite_out   = regwrite_out_reg;
    assign MemtoReg_out   = memtoreg_out_reg;
    assign alu_result_out = alu_out_reg;
    assign load_data_out  = load_out_reg;
    assign fault_out      = fault_out_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, flush, stall_out;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        MemREAD_in;
    logic [1:0]  MemWrite_in;
    logic        MemtoReg_in, RegWrite_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        valid_out, RegWrite_out, MemtoReg_out, fault_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_result_out, load_data_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] ld;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
        .stall_out(stall_out), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .MemREAD_in(MemREAD_in), .MemWrite_in(MemWrite_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .valid_out(valid_out), .rd_out(rd_out),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .alu_result_out(alu_result_out), .load_data_out(load_data_out),
        .fault_out(fault_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid_out pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rd=%0d alu=%h with no expected result", rd_out, alu_result_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn rd=%0d rw=%b mtr=%b alu=%h load=%h fault=%b",
                         rd_out, RegWrite_out, MemtoReg_out, alu_result_out, load_data_out, fault_out);
                chk("rd_out", 32'(rd_out), 32'(e.rd));
                chk("RegWrite_out", 32'(RegWrite_out), 32'(e.rw));
                chk("alu_result_out", alu_result_out, e.alu);
                chk("fault_out", 32'(fault_out), 32'(e.fault));
                if (!e.fault) begin
                    chk("MemtoReg_out", 32'(MemtoReg_out), 32'(e.mtr));
                    chk("load_data_out", load_data_out, e.ld);
                end
            end
        end
    end

    task automatic drive(input logic mr, input logic [1:0] mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw, input logic mtr);
        MemREAD_in    = mr;
        MemWrite_in   = mw;
        funct3_in     = f3;
        alu_result_in = addr;
        store_data_in = data;
        rd_in         = rd;
        RegWrite_in   = rw;
        MemtoReg_in   = mtr;
    endtask

    // Present one op for one clock; returns at the negedge after the accept edge
    task automatic issue(input logic mr, input logic [1:0] mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw, input logic mtr);
        drive(mr, mw, f3, addr, data, rd, rw, mtr);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Answer the outstanding request on its delay-th stall cycle (0 = never)
    task automatic serve(input int delay, input logic [31:0] rdata, output int stalls);
        stalls = 0;
        for (int i = 0; i < 400; i++) begin
            if (!stall_out) break;
            stalls++;
            if (stalls == delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h0;
        end
    endtask

    task automatic load_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int delay, input logic [4:0] rd,
                             input logic [31:0] exp_ld);
        int st;
        exp_q.push_back('{rd: rd, rw: 1'b1, mtr: 1'b1, alu: addr, ld: exp_ld, fault: 1'b0});
        issue(1'b1, 2'b00, f3, addr, 32'h0, rd, 1'b1, 1'b1);
        chk({name, "_req"}, 32'(dmem_req), 32'd1);
        chk({name, "_we"}, 32'(dmem_we), 32'd0);
        chk({name, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({name, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
        serve(delay, rdata, st);
        chk({name, "_stalls"}, st, delay);
    endtask

    task automatic store_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [31:0] wdata, input int delay);
        int st;
        exp_q.push_back('{rd: 5'd0, rw: 1'b0, mtr: 1'b0, alu: addr, ld: 32'h0, fault: 1'b0});
        issue(1'b0, 2'b01, f3, addr, data, 5'd0, 1'b0, 1'b0);
        chk({name, "_req"}, 32'(dmem_req), 32'd1);
        chk({name, "_we"}, 32'(dmem_we), 32'd1);
        chk({name, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({name, "_wstrb"}, 32'(dmem_wstrb), 32'(strb));
        chk({name, "_wdata"}, dmem_wdata, wdata);
        serve(delay, 32'hFFFF_FFFF, st);
        chk({name, "_stalls"}, st, delay);
    endtask

    task automatic fault_case(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [4:0] rd);
        exp_q.push_back('{rd: rd, rw: 1'b0, mtr: 1'b1, alu: addr, ld: 32'h0, fault: 1'b1});
        issue(1'b1, 2'b00, f3, addr, 32'h0, rd, 1'b1, 1'b1);
        chk({name, "_noreq"}, 32'(dmem_req), 32'd0);
        chk({name, "_nostall"}, 32'(stall_out), 32'd0);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int st;
        rst_n = 1'b0;
        valid_in = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_stall_out", 32'(stall_out), 32'd0);
        chk("rst_alu_result_out", alu_result_out, 32'h0);
        chk("rst_load_data_out", load_data_out, 32'h0);
        chk("rst_fault_out", 32'(fault_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU op: one-cycle latency, no memory traffic
        exp_q.push_back('{rd: 5'd5, rw: 1'b1, mtr: 1'b0, alu: 32'h1234, ld: 32'h0, fault: 1'b0});
        issue(1'b0, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        chk("alu_noreq", 32'(dmem_req), 32'd0);
        chk("alu_nostall", 32'(stall_out), 32'd0);
        chk("alu_valid", 32'(valid_out), 32'd1);
        @(negedge clk);
        chk("alu_valid_pulse", 32'(valid_out), 32'd0);

        // Loads
        load_case("lb", 3'b000, 32'h103, 32'h80FF_FF7F, 3, 5'd7, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h103, 32'h80FF_FF7F, 3, 5'd8, 32'h0000_0080);
        load_case("lh", 3'b001, 32'h202, 32'h8001_0000, 2, 5'd9, 32'hFFFF_8001);
        load_case("lhu", 3'b101, 32'h202, 32'h8001_0000, 1, 5'd10, 32'h0000_8001);
        load_case("lw", 3'b010, 32'h200, 32'hDEAD_BEEF, 1, 5'd11, 32'hDEAD_BEEF);

        // Stores
        store_case("sh", 3'b001, 32'h102, 32'hABCD_1234, 4'b1100, 32'h1234_1234, 1);
        store_case("sb", 3'b000, 32'h201, 32'h0000_0055, 4'b0010, 32'h5555_5555, 2);
        store_case("sw", 3'b010, 32'h300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

        // Misaligned and illegal ops fault without a request
        fault_case("lw_misaligned", 3'b010, 32'h101, 5'd12);
        fault_case("lh_misaligned", 3'b001, 32'h103, 5'd13);
        fault_case("illegal_f3", 3'b011, 32'h100, 5'd14);

        // Timeout: no ack ever
        exp_q.push_back('{rd: 5'd15, rw: 1'b0, mtr: 1'b1, alu: 32'h400, ld: 32'h0, fault: 1'b1});
        issue(1'b1, 2'b00, 3'b010, 32'h400, 32'h0, 5'd15, 1'b1, 1'b1);
        serve(0, 32'h0, st);
        chk("timeout_stalls", st, 255);

        // flush squashes the incoming op
        drive(1'b0, 2'b00, 3'b000, 32'h777, 32'h0, 5'd16, 1'b1, 1'b0);
        valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        chk("flush_valid0", 32'(valid_out), 32'd0);
        @(negedge clk);
        chk("flush_valid1", 32'(valid_out), 32'd0);
        chk("flush_nostall", 32'(stall_out), 32'd0);

        // Back-to-back LW then ALU with same-cycle ack
        exp_q.push_back('{rd: 5'd17, rw: 1'b1, mtr: 1'b1, alu: 32'h500, ld: 32'h1122_3344, fault: 1'b0});
        exp_q.push_back('{rd: 5'd18, rw: 1'b1, mtr: 1'b0, alu: 32'hBEEF, ld: 32'h0, fault: 1'b0});
        drive(1'b1, 2'b00, 3'b010, 32'h500, 32'h0, 5'd17, 1'b1, 1'b1);
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_stall", 32'(stall_out), 32'd1);
        drive(1'b0, 2'b00, 3'b000, 32'hBEEF, 32'h0, 5'd18, 1'b1, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        chk("b2b_unstall", 32'(stall_out), 32'd0);
        chk("b2b_lw_rd", 32'(rd_out), 32'd17);
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        chk("b2b_alu_valid", 32'(valid_out), 32'd1);
        chk("b2b_alu_rd", 32'(rd_out), 32'd18);
        @(negedge clk);

        // Reset in the middle of an access drops req immediately
        issue(1'b1, 2'b00, 3'b010, 32'h600, 32'h0, 5'd19, 1'b1, 1'b1);
        chk("rstmid_req_before", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(dmem_req), 32'd0);
        chk("rstmid_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstmid_valid", 32'(valid_out), 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
